// File: rtl/cache_arbiter_if.sv
// Cache-side and memory-side signal bundle for the I/D cache arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface cache_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
);
    logic                  icache_read;
    logic [ADDR_WIDTH-1:0] icache_address;
    logic [LINE_WIDTH-1:0] icache_rdata;
    logic                  icache_resp;

    logic                  dcache_read;
    logic                  dcache_write;
    logic [ADDR_WIDTH-1:0] dcache_address;
    logic [LINE_WIDTH-1:0] dcache_wdata;
    logic [LINE_WIDTH-1:0] dcache_rdata;
    logic                  dcache_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    logic                  grant_sel;

    modport slave (
        input  icache_read, icache_address,
        output icache_rdata, icache_resp,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        output dcache_rdata, dcache_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output grant_sel
    );

    modport master (
        output icache_read, icache_address,
        input  icache_rdata, icache_resp,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  dcache_rdata, dcache_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  grant_sel
    );
endinterface

// File: rtl/cache_arbiter.sv
// Two-requester arbiter sharing one physical-memory port between I- and D-cache.
// Ties alternate via last_grant; every transaction is followed by one IDLE cycle.
module cache_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    cache_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                state;
    state_t                state_d;
    logic                  last_grant;
    logic                  grant_sel_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  d_req;
    logic                  take_i;
    logic                  take_d;
    logic                  done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state: D wins a tie unless it was the last one served
    always_comb begin
        state_d = state;
        take_i  = 1'b0;
        take_d  = 1'b0;
        done    = 1'b0;
        d_req   = bus.dcache_read | bus.dcache_write;
        case (state)
            IDLE: begin
                if (d_req && (!bus.icache_read || !last_grant)) begin
                    take_d  = 1'b1;
                    state_d = SERVE_D;
                end else if (bus.icache_read) begin
                    take_i  = 1'b1;
                    state_d = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture at grant; memory side only ever sees these copies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b0;
            grant_sel_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            if (take_i) begin
                addr_q      <= bus.icache_address;
                write_q     <= 1'b0;
                grant_sel_q <= 1'b0;
            end
            if (take_d) begin
                addr_q      <= bus.dcache_address;
                write_q     <= bus.dcache_write;
                grant_sel_q <= 1'b1;
                if (bus.dcache_write) wdata_q <= bus.dcache_wdata;
            end
            if (done) last_grant <= (state == SERVE_D);
        end
    end

    assign bus.pmem_read    = (state != IDLE) && !write_q;
    assign bus.pmem_write   = (state != IDLE) &&  write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.grant_sel    = grant_sel_q;

    assign bus.icache_rdata = bus.pmem_rdata;
    assign bus.dcache_rdata = bus.pmem_rdata;
    assign bus.icache_resp  = (state == SERVE_I) && bus.pmem_resp;
    assign bus.dcache_resp  = (state == SERVE_D) && bus.pmem_resp;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: inputs change on the falling edge and
// outputs are checked 1ns later, well away from the rising edge.
module tb_cache_arbiter;
    localparam int unsigned AW = 16;
    localparam int unsigned LW = 128;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fall;
        @(negedge clk);
    endtask

    task automatic settle;
        #1;
    endtask

    logic [LW-1:0] line_a5;
    logic [LW-1:0] line_wb;
    logic [LW-1:0] line_x;

    initial begin
        total = 0;
        bad   = 0;
        line_a5 = {16{8'hA5}};
        line_wb = 128'h0123456789ABCDEF0123456789ABCDEF;
        line_x  = 128'h00000000_11111111_22222222_33333333;

        rst_n              = 1'b0;
        bus.icache_read    = 1'b0;
        bus.icache_address = '0;
        bus.dcache_read    = 1'b0;
        bus.dcache_write   = 1'b0;
        bus.dcache_address = '0;
        bus.dcache_wdata   = '0;
        bus.pmem_rdata     = '0;
        bus.pmem_resp      = 1'b0;
        settle();
        chk("rst_pmem_read",  128'(bus.pmem_read), 128'd0);
        chk("rst_pmem_write", 128'(bus.pmem_write), 128'd0);
        chk("rst_grant_sel",  128'(bus.grant_sel), 128'd0);
        chk("rst_addr",       128'(bus.pmem_address), 128'd0);
        chk("rst_wdata",      128'(bus.pmem_wdata), 128'd0);
        fall();
        rst_n = 1'b1;

        // I-only fill, memory answers on the 4th serving cycle
        fall();
        bus.icache_read    = 1'b1;
        bus.icache_address = 16'h1230;
        for (int i = 0; i < 3; i++) begin
            fall(); settle();
            chk("i_pmem_read", 128'(bus.pmem_read), 128'd1);
            chk("i_addr",      128'(bus.pmem_address), 128'h1230);
            chk("i_grant",     128'(bus.grant_sel), 128'd0);
            chk("i_resp_early", 128'(bus.icache_resp), 128'd0);
        end
        fall();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line_a5;
        settle();
        chk("i_pmem_read_last", 128'(bus.pmem_read), 128'd1);
        chk("i_resp",   128'(bus.icache_resp), 128'd1);
        chk("i_rdata",  bus.icache_rdata, line_a5);
        chk("i_d_resp", 128'(bus.dcache_resp), 128'd0);
        fall();
        bus.pmem_resp   = 1'b0;
        bus.icache_read = 1'b0;
        settle();
        chk("i_after_read", 128'(bus.pmem_read), 128'd0);
        chk("i_after_resp", 128'(bus.icache_resp), 128'd0);

        // D writeback
        fall();
        bus.dcache_write   = 1'b1;
        bus.dcache_address = 16'h4000;
        bus.dcache_wdata   = line_wb;
        fall(); settle();
        chk("d_pmem_write", 128'(bus.pmem_write), 128'd1);
        chk("d_pmem_read",  128'(bus.pmem_read), 128'd0);
        chk("d_wdata",      bus.pmem_wdata, line_wb);
        chk("d_addr",       128'(bus.pmem_address), 128'h4000);
        chk("d_grant",      128'(bus.grant_sel), 128'd1);
        fall();
        bus.pmem_resp = 1'b1;
        settle();
        chk("d_resp",      128'(bus.dcache_resp), 128'd1);
        chk("d_i_resp",    128'(bus.icache_resp), 128'd0);
        chk("d_read_hold", 128'(bus.pmem_read), 128'd0);
        fall();
        bus.pmem_resp    = 1'b0;
        bus.dcache_write = 1'b0;
        settle();
        chk("d_idle_write", 128'(bus.pmem_write), 128'd0);
        chk("d_grant_hold", 128'(bus.grant_sel), 128'd1);

        // Reset, then ties alternate starting with D
        fall();
        rst_n = 1'b0;
        fall();
        rst_n = 1'b1;
        bus.icache_read    = 1'b1;
        bus.icache_address = 16'h1000;
        bus.dcache_read    = 1'b1;
        bus.dcache_address = 16'h2000;
        fall(); settle();
        chk("tie1_grant", 128'(bus.grant_sel), 128'd1);
        chk("tie1_addr",  128'(bus.pmem_address), 128'h2000);
        chk("tie1_read",  128'(bus.pmem_read), 128'd1);
        fall();
        bus.pmem_resp   = 1'b1;
        bus.pmem_rdata  = line_x;
        bus.dcache_read = 1'b0;
        settle();
        chk("tie1_d_resp", 128'(bus.dcache_resp), 128'd1);
        chk("tie1_i_resp", 128'(bus.icache_resp), 128'd0);
        chk("tie1_rdata",  bus.dcache_rdata, line_x);
        fall();
        bus.pmem_resp = 1'b0;
        settle();
        chk("tie1_gap", 128'(bus.pmem_read), 128'd0);
        fall(); settle();
        chk("tie1_i_grant", 128'(bus.grant_sel), 128'd0);
        chk("tie1_i_addr",  128'(bus.pmem_address), 128'h1000);
        fall();
        bus.pmem_resp      = 1'b1;
        bus.dcache_read    = 1'b1;
        bus.icache_address = 16'h1100;
        settle();
        chk("tie1_i_resp2", 128'(bus.icache_resp), 128'd1);
        chk("tie1_d_quiet", 128'(bus.dcache_resp), 128'd0);
        fall();
        bus.pmem_resp = 1'b0;
        settle();
        chk("tie2_gap", 128'(bus.pmem_read), 128'd0);
        fall(); settle();
        chk("tie2_grant", 128'(bus.grant_sel), 128'd1);
        chk("tie2_addr",  128'(bus.pmem_address), 128'h2000);
        fall();
        bus.pmem_resp   = 1'b1;
        bus.dcache_read = 1'b0;
        settle();
        chk("tie2_d_resp", 128'(bus.dcache_resp), 128'd1);
        fall();
        bus.pmem_resp = 1'b0;
        fall(); settle();
        chk("tie2_i_addr", 128'(bus.pmem_address), 128'h1100);
        fall();
        bus.pmem_resp   = 1'b1;
        bus.icache_read = 1'b0;
        settle();
        chk("tie2_i_resp", 128'(bus.icache_resp), 128'd1);
        fall();
        bus.pmem_resp = 1'b0;

        // Read+write together selects the write
        fall();
        bus.dcache_read    = 1'b1;
        bus.dcache_write   = 1'b1;
        bus.dcache_address = 16'h5550;
        fall(); settle();
        chk("rw_write", 128'(bus.pmem_write), 128'd1);
        chk("rw_read",  128'(bus.pmem_read), 128'd0);
        fall();
        bus.pmem_resp    = 1'b1;
        bus.dcache_read  = 1'b0;
        bus.dcache_write = 1'b0;
        fall();
        bus.pmem_resp = 1'b0;

        // Address change and request drop mid-transaction
        fall();
        bus.icache_read    = 1'b1;
        bus.icache_address = 16'h1230;
        fall();
        bus.icache_address = 16'h9990;
        bus.icache_read    = 1'b0;
        settle();
        chk("mid_addr1", 128'(bus.pmem_address), 128'h1230);
        fall(); settle();
        chk("mid_addr2", 128'(bus.pmem_address), 128'h1230);
        chk("mid_read",  128'(bus.pmem_read), 128'd1);
        fall();
        bus.pmem_resp = 1'b1;
        settle();
        chk("mid_resp", 128'(bus.icache_resp), 128'd1);
        fall();
        bus.pmem_resp = 1'b0;
        settle();
        chk("mid_idle", 128'(bus.pmem_read), 128'd0);

        // Reset abort during a writeback, then re-arbitration of the held request
        fall();
        bus.dcache_write   = 1'b1;
        bus.dcache_address = 16'h4000;
        fall(); settle();
        chk("ab_write", 128'(bus.pmem_write), 128'd1);
        fall();
        rst_n = 1'b0;
        settle();
        chk("ab_write0", 128'(bus.pmem_write), 128'd0);
        chk("ab_grant0", 128'(bus.grant_sel), 128'd0);
        chk("ab_resp0",  128'(bus.dcache_resp), 128'd0);
        chk("ab_addr0",  128'(bus.pmem_address), 128'd0);
        fall();
        rst_n = 1'b1;
        fall(); settle();
        chk("ab_rearb_write", 128'(bus.pmem_write), 128'd1);
        chk("ab_rearb_grant", 128'(bus.grant_sel), 128'd1);
        fall();
        bus.pmem_resp    = 1'b1;
        bus.dcache_write = 1'b0;
        settle();
        chk("ab_resp", 128'(bus.dcache_resp), 128'd1);
        fall();
        bus.pmem_resp = 1'b0;

        // Stray memory response while idle
        fall();
        bus.pmem_resp = 1'b1;
        settle();
        chk("stray_i_resp", 128'(bus.icache_resp), 128'd0);
        chk("stray_d_resp", 128'(bus.dcache_resp), 128'd0);
        fall();
        bus.pmem_resp = 1'b0;
        settle();
        chk("stray_read",  128'(bus.pmem_read), 128'd0);
        chk("stray_write", 128'(bus.pmem_write), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
